// File: rtl/gfx256_pkg.sv
// Shared types and helpers for the gfx256 Wishbone master read/write port.
// Holds the port FSM state encoding and the byte-offset width derivation.
package gfx256_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    // Number of byte-offset address bits for a data bus of wid bits.
    function automatic int lsb_from_wid(input int wid);
        return $clog2(wid / 8);
    endfunction

endpackage

// File: rtl/gfx256_wbm_rw_port.sv
// Single-outstanding Wishbone master port: accepts one read or write from the arbiter,
// runs one classic Wishbone cycle with timeout, then pulses ack_o and idles one gap cycle.
module gfx256_wbm_rw_port
    import gfx256_pkg::*;
#(
    parameter int WID     = 256,
    parameter int TIMEOUT = 1024,
    localparam int LSB    = lsb_from_wid(WID),
    localparam int SW     = WID / 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              read_request_i,
    input  logic              write_request_i,
    input  logic [31-LSB:0]   addr_i,
    input  logic              we_i,
    input  logic [SW-1:0]     sel_i,
    input  logic [WID-1:0]    dat_i,
    output logic [WID-1:0]    dat_o,
    output logic              ack_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [31:0]       wbm_adr_o,
    output logic [SW-1:0]     wbm_sel_o,
    output logic [WID-1:0]    wbm_dat_o,
    input  logic [WID-1:0]    wbm_dat_i,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i,
    output logic              busy_o,
    output logic              err_o,
    output logic              timeout_o,
    input  logic              clr_status_i
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e            state_r;
    state_e            next_state_s;
    logic [CW-1:0]     cnt_r;
    logic [31-LSB:0]   adr_r;
    logic [SW-1:0]     sel_r;
    logic [WID-1:0]    wdat_r;
    logic [WID-1:0]    rdat_r;
    logic              we_r;
    logic              cyc_r;
    logic              ack_r;
    logic              busy_r;
    logic              err_r;
    logic              to_r;
    logic              accept_s;
    logic              timeout_hit_s;
    logic              err_set_s;
    logic              rd_capture_s;
    logic              we_unused_s;

    // The direction comes from which request line is raised; we_i is informational only.
    assign we_unused_s = we_i;

    // Next-state decode and per-cycle event strobes.
    always_comb begin
        next_state_s  = state_r;
        accept_s      = 1'b0;
        timeout_hit_s = 1'b0;
        err_set_s     = 1'b0;
        rd_capture_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (read_request_i || write_request_i) begin
                    accept_s     = 1'b1;
                    next_state_s = ST_BUS;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (wbm_err_i) begin
                    err_set_s    = 1'b1;
                    next_state_s = ST_DONE;
                end else if (wbm_ack_i) begin
                    rd_capture_s = ~we_r;
                    next_state_s = ST_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    timeout_hit_s = 1'b1;
                    next_state_s  = ST_DONE;
                end else begin
                    next_state_s = ST_BUS;
                end
            end
            ST_DONE: next_state_s = ST_GAP;
            ST_GAP:  next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register plus registered bus-control and handshake outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            cyc_r   <= 1'b0;
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            cyc_r   <= (next_state_s == ST_BUS);
            ack_r   <= (next_state_s == ST_DONE);
            busy_r  <= (next_state_s != ST_IDLE);
        end
    end

    // Bus-cycle counter, restarted whenever the FSM is outside BUS.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= {CW{1'b0}};
        end else if (state_r == ST_BUS) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= {CW{1'b0}};
        end
    end

    // Request capture; these hold steady for the whole bus cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            adr_r  <= '0;
            sel_r  <= '0;
            wdat_r <= '0;
            we_r   <= 1'b0;
        end else if (accept_s) begin
            adr_r  <= addr_i;
            sel_r  <= sel_i;
            wdat_r <= dat_i;
            we_r   <= write_request_i;
        end
    end

    // Read data return register; holds until the next clean read completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdat_r <= '0;
        end else if (rd_capture_s) begin
            rdat_r <= wbm_dat_i;
        end
    end

    // Sticky status flags; a set in the same cycle beats a clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_r <= 1'b0;
            to_r  <= 1'b0;
        end else begin
            if (err_set_s) begin
                err_r <= 1'b1;
            end else if (clr_status_i) begin
                err_r <= 1'b0;
            end
            if (timeout_hit_s) begin
                to_r <= 1'b1;
            end else if (clr_status_i) begin
                to_r <= 1'b0;
            end
        end
    end

    assign wbm_cyc_o = cyc_r;
    assign wbm_stb_o = cyc_r;
    assign wbm_we_o  = we_r;
    assign wbm_adr_o = {adr_r, {LSB{1'b0}}};
    assign wbm_sel_o = sel_r;
    assign wbm_dat_o = wdat_r;
    assign dat_o     = rdat_r;
    assign ack_o     = ack_r;
    assign busy_o    = busy_r;
    assign err_o     = err_r;
    assign timeout_o = to_r;

endmodule

// File: tb/tb_gfx256_wbm_rw_port.sv
// Self-checking bench for gfx256_wbm_rw_port (WID=256, TIMEOUT=8) with a
// transaction-level model of the status flags and returned read data.
module tb_gfx256_wbm_rw_port;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          read_request_i = 1'b0;
    logic          write_request_i = 1'b0;
    logic [26:0]   addr_i = '0;
    logic          we_i = 1'b0;
    logic [31:0]   sel_i = '0;
    logic [255:0]  dat_i = '0;
    logic [255:0]  dat_o;
    logic          ack_o;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0]   wbm_adr_o;
    logic [31:0]   wbm_sel_o;
    logic [255:0]  wbm_dat_o;
    logic [255:0]  wbm_dat_i = '0;
    logic          wbm_ack_i = 1'b0;
    logic          wbm_err_i = 1'b0;
    logic          busy_o, err_o, timeout_o;
    logic          clr_status_i = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [255:0]  model_dat = '0;
    logic          model_err = 1'b0;
    logic          model_to  = 1'b0;

    gfx256_wbm_rw_port #(.WID(256), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .read_request_i(read_request_i), .write_request_i(write_request_i),
        .addr_i(addr_i), .we_i(we_i), .sel_i(sel_i), .dat_i(dat_i),
        .dat_o(dat_o), .ack_o(ack_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_sel_o(wbm_sel_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .busy_o(busy_o), .err_o(err_o), .timeout_o(timeout_o),
        .clr_status_i(clr_status_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({wbm_cyc_o, wbm_stb_o, ack_o, busy_o} !== 4'b0000) begin
            errors++;
            $display("FAIL %s_ctrl: cyc/stb/ack/busy=%b%b%b%b want 0000", tag, wbm_cyc_o, wbm_stb_o, ack_o, busy_o);
        end
        checks++;
        if ({err_o, timeout_o, dat_o} !== {model_err, model_to, model_dat}) begin
            errors++;
            $display("FAIL %s_status: err=%b to=%b dat=%h want err=%b to=%b dat=%h",
                     tag, err_o, timeout_o, dat_o, model_err, model_to, model_dat);
        end
    endtask

    // One complete access: request at cycle N, slave answers after `waits` wait states.
    task automatic do_access(input bit wr, input bit both, input int waits, input bit err_resp,
                             input bit clr_same, input bit hold_req, input logic [26:0] a,
                             input logic [31:0] s, input logic [255:0] d, input logic [255:0] rd);
        logic [31:0] exp_adr;
        exp_adr = {a, 5'b00000};
        read_request_i  = !wr || both;
        write_request_i = wr;
        we_i = wr;
        addr_i = a; sel_i = s; dat_i = d;
        step();
        if (!hold_req) begin
            read_request_i = 1'b0; write_request_i = 1'b0;
        end
        for (int c = 0; c <= waits; c++) begin
            checks++;
            if ({wbm_cyc_o, wbm_stb_o, busy_o, ack_o} !== 4'b1110) begin
                errors++;
                $display("FAIL bus_ctrl c%0d: cyc/stb/busy/ack=%b%b%b%b want 1110", c, wbm_cyc_o, wbm_stb_o, busy_o, ack_o);
            end
            checks++;
            if ({wbm_adr_o, wbm_sel_o, wbm_we_o, wbm_dat_o} !== {exp_adr, s, wr, d}) begin
                errors++;
                $display("FAIL bus_lines c%0d: adr=%h sel=%h we=%b wdat=%h want adr=%h sel=%h we=%b wdat=%h",
                         c, wbm_adr_o, wbm_sel_o, wbm_we_o, wbm_dat_o, exp_adr, s, wr, d);
            end
            if (c == waits) begin
                wbm_err_i = err_resp;
                wbm_ack_i = err_resp ? 1'($urandom_range(0, 1)) : 1'b1;
                wbm_dat_i = rd;
                clr_status_i = clr_same;
            end
            step();
        end
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; clr_status_i = 1'b0;
        wbm_dat_i = rand256();
        if (clr_same) begin model_err = 1'b0; model_to = 1'b0; end
        if (err_resp) model_err = 1'b1;
        else if (!wr) model_dat = rd;
        checks++;
        if ({ack_o, wbm_cyc_o, wbm_stb_o, busy_o} !== 4'b1001) begin
            errors++;
            $display("FAIL done_ctrl: ack/cyc/stb/busy=%b%b%b%b want 1001", ack_o, wbm_cyc_o, wbm_stb_o, busy_o);
        end
        checks++;
        if ({err_o, timeout_o, dat_o} !== {model_err, model_to, model_dat}) begin
            errors++;
            $display("FAIL done_status: err=%b to=%b dat=%h want err=%b to=%b dat=%h",
                     err_o, timeout_o, dat_o, model_err, model_to, model_dat);
        end
        step();
        checks++;
        if ({ack_o, wbm_cyc_o, busy_o} !== 3'b001) begin
            errors++;
            $display("FAIL gap_ctrl: ack/cyc/busy=%b%b%b want 001", ack_o, wbm_cyc_o, busy_o);
        end
        step();
        read_request_i = 1'b0; write_request_i = 1'b0;
        check_idle_outputs("idle_after");
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #23;
        check_idle_outputs("reset");
        checks++;
        if ({wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o} !== '0) begin
            errors++;
            $display("FAIL reset_lines: we=%b adr=%h sel=%h wdat=%h want all 0", wbm_we_o, wbm_adr_o, wbm_sel_o, wbm_dat_o);
        end
        rst_ni = 1'b1;
        step();
        check_idle_outputs("post_reset");
    endtask

    task automatic test_read_zero_wait();
        logic [255:0] pat;
        pat = {32{8'hA5}};
        do_access(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 27'h0000123, 32'hFFFFFFFF, rand256(), pat);
    endtask

    task automatic test_write_wait();
        do_access(1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b1, 27'($urandom), 32'h0000FFFF, rand256(), rand256());
    endtask

    task automatic test_error();
        do_access(1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 27'($urandom), $urandom, rand256(), rand256());
        test_clear_status();
        do_access(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 27'($urandom), $urandom, rand256(), rand256());
        test_clear_status();
    endtask

    task automatic test_clear_status();
        clr_status_i = 1'b1;
        step();
        clr_status_i = 1'b0;
        model_err = 1'b0; model_to = 1'b0;
        check_idle_outputs("clear");
    endtask

    task automatic test_timeout();
        int n;
        read_request_i = 1'b1;
        addr_i = 27'($urandom);
        step();
        read_request_i = 1'b0;
        n = 0;
        while (wbm_cyc_o === 1'b1 && n < 50) begin
            n++;
            step();
        end
        model_to = 1'b1;
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL timeout_len: bus cycles=%0d want 8", n);
        end
        checks++;
        if ({ack_o, timeout_o, err_o, dat_o} !== {1'b1, model_to, model_err, model_dat}) begin
            errors++;
            $display("FAIL timeout_done: ack=%b to=%b err=%b dat=%h want ack=1 to=%b err=%b dat=%h",
                     ack_o, timeout_o, err_o, dat_o, model_to, model_err, model_dat);
        end
        step();
        checks++;
        if (ack_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_single_ack: ack=%b want 0", ack_o);
        end
        step();
        check_idle_outputs("timeout_idle");
        test_clear_status();
    endtask

    task automatic test_reset_mid_bus();
        int acks;
        read_request_i = 1'b1;
        addr_i = 27'($urandom);
        step();
        read_request_i = 1'b0;
        step();
        #2;
        rst_ni = 1'b0;
        #1;
        model_dat = '0; model_err = 1'b0; model_to = 1'b0;
        check_idle_outputs("async_reset");
        #2;
        rst_ni = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            acks += int'(ack_o === 1'b1);
        end
        checks++;
        if (acks !== 0) begin
            errors++;
            $display("FAIL reset_no_ack: ack pulses=%0d want 0", acks);
        end
        do_access(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 27'($urandom), $urandom, rand256(), rand256());
    endtask

    task automatic test_back_to_back_random();
        for (int k = 0; k < 25; k++) begin
            do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                      27'($urandom), $urandom, rand256(), rand256());
        end
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_error();
        test_timeout();
        test_reset_mid_bus();
        test_back_to_back_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
